// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg: shared constants for the flash word-reader arbiter.
//   DEF_AW / DEF_DW : default word address / data widths
//   NCLI            : number of arbitrated clients
//   ST_*            : arbiter FSM state encoding
package flash_arb_pkg;
  localparam int DEF_AW = 23;
  localparam int DEF_DW = 16;
  localparam int NCLI   = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIT   = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;
endpackage

// File: rtl/flash_word_cache.sv
// flash_word_cache: one-entry last-read cache (tag, data, valid).
//   iclk, ireset_n : clock, synchronous active-low reset (clears valid)
//   inval          : clear valid on the next edge; wins over wr
//   wr, wr_tag, wr_data : fill the entry and mark it valid
//   addr, hit      : combinational tag compare against addr
//   rd_data        : stored word
module flash_word_cache
  import flash_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          iclk,
  input  logic          ireset_n,
  input  logic          inval,
  input  logic          wr,
  input  logic [AW-1:0] wr_tag,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [DW-1:0] rd_data
);
  logic          valid;
  logic [AW-1:0] tag;

  always_ff @(posedge iclk) begin
    if (!ireset_n)  valid <= 1'b0;
    else if (inval) valid <= 1'b0;
    else if (wr)    valid <= 1'b1;
  end

  // Tag/data need no reset: they are only observed through valid.
  always_ff @(posedge iclk) begin
    if (wr) begin
      tag     <= wr_tag;
      rd_data <= wr_data;
    end
  end

  assign hit = valid && (tag == addr);
endmodule

// File: rtl/flash_arbiter.sv
// flash_arbiter: round-robin arbiter sharing one toggle-handshake flash word
// reader between client 0 (cartridge ROM) and client 1 (loader/DMA), with a
// one-word last-read cache per client. A request is pending while req != ack.
//   iclk, ireset_n          : clock, synchronous active-low reset
//   ic<n>_addr, ic<n>_req   : client word address / request toggle
//   oc<n>_dout, oc<n>_ack   : client read data / acknowledge toggle
//   iinval                  : pulse, invalidates both caches
//   ofl_addr, ofl_req       : flash reader address / request toggle
//   ifl_dout, ifl_ack       : flash reader data / acknowledge toggle
//   ogrant                  : client being served (0 when idle)
//   obusy                   : FSM not in IDLE
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic          iclk,
  input  logic          ireset_n,
  input  logic [AW-1:0] ic0_addr,
  input  logic          ic0_req,
  output logic [DW-1:0] oc0_dout,
  output logic          oc0_ack,
  input  logic [AW-1:0] ic1_addr,
  input  logic          ic1_req,
  output logic [DW-1:0] oc1_dout,
  output logic          oc1_ack,
  input  logic          iinval,
  output logic [AW-1:0] ofl_addr,
  output logic          ofl_req,
  input  logic [DW-1:0] ifl_dout,
  input  logic          ifl_ack,
  output logic          ogrant,
  output logic          obusy
);
  logic [1:0]             state;
  logic                   last;
  logic                   drop_fill;
  logic [AW-1:0]          cur_addr;
  logic                   p0, p1, sel;
  logic                   fill_done;
  logic [NCLI-1:0][AW-1:0] c_addr;
  logic [NCLI-1:0]         c_hit;
  logic [NCLI-1:0]         c_wr;
  logic [NCLI-1:0][DW-1:0] c_data;

  assign p0        = ic0_req ^ oc0_ack;
  assign p1        = ic1_req ^ oc1_ack;
  // Contention goes to the client not served last; otherwise whoever is pending.
  assign sel       = (p0 && p1) ? ~last : p1;
  assign fill_done = (state == ST_WAIT) && (ifl_ack == ofl_req);
  assign obusy     = (state != ST_IDLE);
  assign c_addr    = {ic1_addr, ic0_addr};

  for (genvar i = 0; i < NCLI; i++) begin : g_cache
    // A fill is dropped if an invalidate landed anywhere in the transaction,
    // including the completing cycle itself.
    assign c_wr[i] = CACHE_EN && fill_done && (ogrant == 1'(i)) && !drop_fill && !iinval;

    flash_word_cache #(.AW(AW), .DW(DW)) u_cache (
      .iclk    (iclk),
      .ireset_n(ireset_n),
      .inval   (iinval),
      .wr      (c_wr[i]),
      .wr_tag  (cur_addr),
      .wr_data (ifl_dout),
      .addr    (c_addr[i]),
      .hit     (c_hit[i]),
      .rd_data (c_data[i])
    );
  end

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      // Absorb any outstanding toggles so nothing is pending after reset.
      oc0_ack   <= ic0_req;
      oc1_ack   <= ic1_req;
      ofl_req   <= ifl_ack;
      oc0_dout  <= '0;
      oc1_dout  <= '0;
      ofl_addr  <= '0;
      ogrant    <= 1'b0;
      last      <= 1'b1;
      drop_fill <= 1'b0;
      cur_addr  <= '0;
      state     <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (p0 || p1) begin
            cur_addr <= sel ? ic1_addr : ic0_addr;
            ogrant   <= sel;
            state    <= (CACHE_EN && c_hit[sel]) ? ST_HIT : ST_ISSUE;
          end
        end
        ST_HIT: begin
          if (ogrant) begin
            oc1_dout <= c_data[1];
            oc1_ack  <= ~oc1_ack;
          end else begin
            oc0_dout <= c_data[0];
            oc0_ack  <= ~oc0_ack;
          end
          last   <= ogrant;
          ogrant <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_ISSUE: begin
          if (iinval) drop_fill <= 1'b1;
          // Hold off while a reader transaction abandoned by reset is still
          // out; its late ack would otherwise be taken as ours.
          if (ofl_req == ifl_ack) begin
            ofl_addr <= cur_addr;
            ofl_req  <= ~ofl_req;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (iinval) drop_fill <= 1'b1;
          if (fill_done) begin
            if (ogrant) begin
              oc1_dout <= ifl_dout;
              oc1_ack  <= ~oc1_ack;
            end else begin
              oc0_dout <= ifl_dout;
              oc0_ack  <= ~oc0_ack;
            end
            last      <= ogrant;
            ogrant    <= 1'b0;
            drop_fill <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

Two-port arbiter that shares the single toggle-handshake flash word reader between two requesters: client 0, the cartridge ROM read port, and client 1, the loader/DMA read port. It sits between the clients and the flash reader's `ifl_*` port. It grants requests round-robin and keeps a one-word last-read cache per client, so repeated reads of the same word never touch flash. All handshakes are toggle style: a request is pending while req != ack.

## Interface
Parameters:
- `AW`, 23: word address width.
- `DW`, 16: data word width.
- `CACHE_EN`, 1: 1 enables the per-client last-word cache; 0 sends every request to flash.

Ports:
- `iclk`  in  1  system clock (54 MHz). Single clock domain.
- `ireset_n`  in  1  reset, synchronous, active-low.
- `ic0_addr`  in  AW  client 0 word address; held stable while the request is pending.
- `ic0_req`  in  1  client 0 request toggle.
- `oc0_dout`  out  DW  client 0 read data; valid when `oc0_ack` == `ic0_req`.
- `oc0_ack`  out  1  client 0 acknowledge toggle.
- `ic1_addr`, `ic1_req`, `oc1_dout`, `oc1_ack`: identical set for client 1.
- `iinval`  in  1  single-cycle pulse that invalidates both caches.
- `ofl_addr`  out  AW  address to the flash reader.
- `ofl_req`  out  1  request toggle to the flash reader.
- `ifl_dout`  in  DW  data from the flash reader.
- `ifl_ack`  in  1  acknowledge toggle from the flash reader.
- `ogrant`  out  1  client currently being served; 0 when idle.
- `obusy`  out  1  high in any state other than IDLE.

## Operation
- Pending flags: `p0 = ic0_req ^ oc0_ack` and `p1 = ic1_req ^ oc1_ack`.
- Reset (`ireset_n` low at a clock edge) sets:
  - `oc0_ack <= ic0_req` and `oc1_ack <= ic1_req`, so nothing is pending after reset.
  - `ofl_req <= ifl_ack`.
  - `oc*_dout`, `ofl_addr`, `ogrant` to 0.
  - Both cache valid bits to 0, the round-robin pointer `last` to 1 (client 0 wins first), and the state to IDLE.
- Reset mid-transaction abandons the transaction without retry. After reset, the next flash request is issued only once `ofl_req` == `ifl_ack`.
- FSM states: IDLE, HIT, ISSUE, WAIT.
- IDLE:
  - Selection: if only one client is pending, select it. If both are pending, select `~last`.
  - Latch the selected address into `cur_addr` and set `ogrant` to the selected client.
  - If `CACHE_EN` is set, the selected cache entry is valid and its tag equals the address, go to HIT. Otherwise go to ISSUE.
- HIT: drive the cached word to `oc<g>_dout`, toggle `oc<g>_ack`, set `last <= g`, go to IDLE.
- ISSUE: `ofl_addr <= cur_addr`, toggle `ofl_req`, go to WAIT.
- WAIT: hold until `ifl_ack` == `ofl_req`. Then:
  - `oc<g>_dout <= ifl_dout` and toggle `oc<g>_ack`.
  - Write the cache entry (tag `cur_addr`, data, valid=1), unless `iinval` was seen during this transaction.
  - Set `last <= g` and go to IDLE.
- Invalidate:
  - `iinval` clears both valid bits on the next edge.
  - An invalidate during ISSUE or WAIT sets the sticky `drop_fill` flag. The completing fill then returns data to the client but leaves the valid bit clear. `drop_fill` clears on return to IDLE.
  - `iinval` in the same cycle as a HIT still serves that hit from the old data, and the entry is invalid afterwards.
- A client that toggles req again before its ack is a protocol error. It is not detected and behaviour is undefined.

## Timing
- Cache hit: pending seen in IDLE at cycle t; HIT at t+1; ack toggles at the edge ending t+1. Latency is 2 cycles.
- Miss: `ofl_req` toggles at the end of t+1. The client ack toggles one edge after `ifl_ack` matches `ofl_req`. Arbiter overhead is 3 cycles plus flash latency, which is about 15 cycles at 54 MHz.
- Back-to-back requests: IDLE is re-entered between every two transactions, so at most one transaction completes per 2 cycles.
- Fairness: with both clients continuously pending, grants strictly alternate. Neither client waits more than one other transaction.
- The flash reader's address is stable from ISSUE until WAIT exits.

## Structure
- Package `flash_arb_pkg` holds:
  - the state encoding localparams `ST_IDLE`, `ST_HIT`, `ST_ISSUE`, `ST_WAIT`;
  - the `AW` and `DW` defaults.
- Sub-module `flash_word_cache` is a one-entry cache with tag, data and valid, plus `hit` compare, `wr` and `inval` ports. It is instantiated once per client; the top holds the FSM and the arbitration pointer.

## Test plan
- Reset with `ic0_req`=1 and `ic1_req`=0 -> after reset `oc0_ack`=1, `oc1_ack`=0, `obusy`=0, and no `ofl_req` toggle.
- Client 0 reads 0x000100 with the flash model returning 0xA55A -> one `ofl_req` toggle, `oc0_dout`=0xA55A, ack one cycle after `ifl_ack`. A repeat read of 0x000100 -> no `ofl_req` toggle, ack in 2 cycles, data 0xA55A.
- Both clients toggle in the same cycle (c0 at 0x10, c1 at 0x20) -> c0 served first, then c1. With both kept pending for 4 more requests each, `ogrant` alternates 0,1,0,1.
- `iinval` pulsed during WAIT of a c1 miss at 0x40 -> c1 receives the data, and a re-read of 0x40 issues a new flash request.
- `ireset_n` asserted during WAIT -> the pending flash ack is ignored; after release the next request waits for `ofl_req` == `ifl_ack` and then completes correctly.
- `CACHE_EN`=0 with a repeated read of 0x000100 -> every request toggles `ofl_req`.
